sdram_responder: RTL and testbench

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_pkg.sv | 59 +++++
 rtl/sdram_responder_if.sv | 26 ++
 rtl/sdram_resp_mem.sv | 27 ++
 rtl/sdram_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, mode-register fields, bank state, error bits.
package sdram_pkg;

    localparam int unsigned NUM_BANKS = 4;
    localparam int unsigned BA_W      = 2;
    localparam int unsigned DQ_W      = 16;
    localparam int unsigned ERR_W     = 4;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_MRS   = 4'b0000,
        CMD_REF   = 4'b0001,
        CMD_PRE   = 4'b0010,
        CMD_ACT   = 4'b0011,
        CMD_WRITE = 4'b0100,
        CMD_READ  = 4'b0101,
        CMD_NOP   = 4'b0111
    } sdram_cmd_e;

    localparam logic [2:0] BL_1 = 3'b000;
    localparam logic [2:0] BL_2 = 3'b001;
    localparam logic [2:0] BL_4 = 3'b010;
    localparam logic [2:0] BL_8 = 3'b011;
    localparam logic [2:0] CL_2 = 3'd2;
    localparam logic [2:0] CL_3 = 3'd3;

    typedef enum logic {
        BANK_IDLE,
        BANK_ACTIVE
    } bank_state_e;

    localparam int unsigned ERR_IDLE = 0;
    localparam int unsigned ERR_ACT  = 1;
    localparam int unsigned ERR_INIT = 2;
    localparam int unsigned ERR_TRCD = 3;

    function automatic sdram_cmd_e decode_cmd(input logic cke, input logic cs_n,
                                              input logic ras_n, input logic cas_n,
                                              input logic we_n);
        logic [3:0] raw;
        raw = {cs_n, ras_n, cas_n, we_n};
        if (!cke || cs_n) return CMD_NOP;
        case (raw)
            CMD_MRS, CMD_REF, CMD_PRE, CMD_ACT, CMD_WRITE, CMD_READ: return sdram_cmd_e'(raw);
            default: return CMD_NOP;
        endcase
    endfunction

    // Sequential bursts of 1/2/4/8 with CL 2 or 3 are the only supported modes.
    function automatic logic mode_valid(input logic [6:0] mode);
        logic bl_ok;
        logic cl_ok;
        bl_ok = (mode[2:0] == BL_1) || (mode[2:0] == BL_2) ||
                (mode[2:0] == BL_4) || (mode[2:0] == BL_8);
        cl_ok = (mode[6:4] == CL_2) || (mode[6:4] == CL_3);
        return bl_ok && cl_ok && !mode[3];
    endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// Controller-to-device command bus (everything except the bidirectional DQ).
interface sdram_responder_if
    import sdram_pkg::*;
#(
    parameter int unsigned AW = 12
);
    logic            clock_enable;
    logic            cs_n;
    logic            ras_n;
    logic            cas_n;
    logic            we_n;
    logic [BA_W-1:0] bank_addr;
    logic [AW-1:0]   addr;
    logic            data_mask_low;
    logic            data_mask_high;

    modport master (
        output clock_enable, cs_n, ras_n, cas_n, we_n, bank_addr, addr,
               data_mask_low, data_mask_high
    );

    modport slave (
        input clock_enable, cs_n, ras_n, cas_n, we_n, bank_addr, addr,
              data_mask_low, data_mask_high
    );
endinterface

// File: rtl/sdram_resp_mem.sv
// Simple dual-port 16-bit RAM with byte enables and a registered read; contents survive reset.
module sdram_resp_mem
    import sdram_pkg::*;
#(
    parameter int unsigned AW = 13
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [1:0]      be_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DQ_W-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [DQ_W-1:0] rdata_o
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [DQ_W-1:0] mem_q [DEPTH];
    logic [DQ_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i && be_i[0]) mem_q[waddr_i][7:0]  <= wdata_i[7:0];
        if (we_i && be_i[1]) mem_q[waddr_i][15:8] <= wdata_i[15:8];
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sdram_responder.sv
// SDRAM device model: decodes the command bus, tracks per-bank state and serves bursts from RAM.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_WIDTH = 12,
    parameter int unsigned COL_WIDTH = 9,
    parameter int unsigned ROW_KEEP  = 2,
    parameter int unsigned TRCD      = 2
) (
    input  logic             clk,
    input  logic             rst,
    sdram_responder_if.slave bus,
    inout  wire  [DQ_W-1:0]  data,
    output logic             init_done,
    output logic [ERR_W-1:0] err
);
    localparam int unsigned AW = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH;
    localparam int unsigned MW = BA_W + ROW_KEEP + COL_WIDTH;
    localparam int unsigned CW = $clog2(TRCD + 2);

    bank_state_e         bank_st_q [NUM_BANKS];
    bank_state_e         bank_st_d [NUM_BANKS];
    logic [ROW_KEEP-1:0] row_q     [NUM_BANKS];
    logic [ROW_KEEP-1:0] row_d     [NUM_BANKS];
    logic [CW-1:0]       act_cnt_q [NUM_BANKS];
    logic [CW-1:0]       act_cnt_d [NUM_BANKS];

    logic             init_q, init_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       cl_q, cl_d;
    logic [1:0]       bl_q, bl_d;

    logic                 bst_act_q, bst_act_d, bst_wr_q, bst_wr_d, bst_ap_q, bst_ap_d;
    logic [BA_W-1:0]      bst_bank_q, bst_bank_d;
    logic [ROW_KEEP-1:0]  bst_row_q, bst_row_d;
    logic [COL_WIDTH-1:0] bst_col_q, bst_col_d;
    logic [2:0]           bst_idx_q, bst_idx_d;

    logic            rd_v_q, rd_v_d, p1_v_q, p1_v_d, oe_q, oe_d;
    logic [DQ_W-1:0] p1_dat_q, p1_dat_d, dout_q, dout_d;

    logic [AW-1:0]        cmd_addr;
    logic                 unused_addr;
    sdram_cmd_e           cmd;
    logic [2:0]           bl_m1;
    logic [COL_WIDTH-1:0] col_mask, bst_cur_col;
    logic                 rw_ok, rd_issue, mem_we;
    logic [MW-1:0]        mem_waddr, mem_raddr;
    logic [DQ_W-1:0]      mem_rdata;

    // Row bits above ROW_KEEP alias onto stored rows, so only part of addr reaches the RAM.
    assign cmd_addr    = bus.addr;
    assign unused_addr = ^cmd_addr;
    assign cmd         = decode_cmd(bus.clock_enable, bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n);

    assign bl_m1       = 3'((4'd1 << bl_q) - 4'd1);
    assign col_mask    = COL_WIDTH'(bl_m1);
    assign bst_cur_col = (bst_col_q & ~col_mask) | ((bst_col_q + COL_WIDTH'(bst_idx_q)) & col_mask);
    assign rw_ok       = (cmd == CMD_READ || cmd == CMD_WRITE) && init_q &&
                         (bank_st_q[bus.bank_addr] == BANK_ACTIVE);

    always_comb begin
        bank_st_d  = bank_st_q;
        row_d      = row_q;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            act_cnt_d[b] = (act_cnt_q[b] < CW'(TRCD)) ? act_cnt_q[b] + CW'(1) : act_cnt_q[b];
        end
        init_d     = init_q;
        err_d      = err_q;
        cl_d       = cl_q;
        bl_d       = bl_q;
        bst_act_d  = bst_act_q;
        bst_wr_d   = bst_wr_q;
        bst_ap_d   = bst_ap_q;
        bst_bank_d = bst_bank_q;
        bst_row_d  = bst_row_q;
        bst_col_d  = bst_col_q;
        bst_idx_d  = bst_idx_q;
        mem_we     = 1'b0;
        rd_issue   = 1'b0;
        mem_waddr  = {bst_bank_q, bst_row_q, bst_cur_col};
        mem_raddr  = {bst_bank_q, bst_row_q, bst_cur_col};

        // An accepted READ/WRITE truncates the running burst, so it only advances otherwise.
        if (bst_act_q && !rw_ok) begin
            mem_we   = bst_wr_q;
            rd_issue = !bst_wr_q;
            if (bst_idx_q == bl_m1) begin
                bst_act_d = 1'b0;
                if (bst_ap_q) bank_st_d[bst_bank_q] = BANK_IDLE;
            end else begin
                bst_idx_d = bst_idx_q + 3'd1;
            end
        end

        case (cmd)
            CMD_MRS: begin
                if (mode_valid(cmd_addr[6:0])) begin
                    cl_d   = cmd_addr[6:4];
                    bl_d   = cmd_addr[1:0];
                    init_d = 1'b1;
                end else begin
                    err_d[ERR_INIT] = 1'b1;
                    init_d          = 1'b0;
                end
            end
            CMD_REF: begin
                for (int b = 0; b < int'(NUM_BANKS); b++) begin
                    if (bank_st_q[b] != BANK_IDLE) err_d[ERR_ACT] = 1'b1;
                end
            end
            CMD_PRE: begin
                if (cmd_addr[10]) begin
                    for (int b = 0; b < int'(NUM_BANKS); b++) bank_st_d[b] = BANK_IDLE;
                end else begin
                    bank_st_d[bus.bank_addr] = BANK_IDLE;
                end
            end
            CMD_ACT: begin
                if (!init_q) begin
                    err_d[ERR_INIT] = 1'b1;
                end else begin
                    if (bank_st_q[bus.bank_addr] == BANK_ACTIVE) err_d[ERR_ACT] = 1'b1;
                    bank_st_d[bus.bank_addr] = BANK_ACTIVE;
                    row_d[bus.bank_addr]     = cmd_addr[ROW_KEEP-1:0];
                    act_cnt_d[bus.bank_addr] = CW'(1);
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (!init_q) begin
                    err_d[ERR_INIT] = 1'b1;
                end else if (!rw_ok) begin
                    err_d[ERR_IDLE] = 1'b1;
                end else begin
                    if (act_cnt_q[bus.bank_addr] < CW'(TRCD)) err_d[ERR_TRCD] = 1'b1;
                    mem_waddr  = {bus.bank_addr, row_q[bus.bank_addr], cmd_addr[COL_WIDTH-1:0]};
                    mem_raddr  = mem_waddr;
                    mem_we     = (cmd == CMD_WRITE);
                    rd_issue   = (cmd == CMD_READ);
                    bst_act_d  = (bl_q != 2'd0);
                    bst_wr_d   = (cmd == CMD_WRITE);
                    bst_ap_d   = cmd_addr[10];
                    bst_bank_d = bus.bank_addr;
                    bst_row_d  = row_q[bus.bank_addr];
                    bst_col_d  = cmd_addr[COL_WIDTH-1:0];
                    bst_idx_d  = 3'd1;
                    if (bl_q == 2'd0 && cmd_addr[10]) bank_st_d[bus.bank_addr] = BANK_IDLE;
                end
            end
            default: ;
        endcase
    end

    // Read return: RAM latency is one stage, CL=3 adds one more before the DQ register.
    always_comb begin
        rd_v_d   = rd_issue;
        p1_v_d   = rd_v_q;
        p1_dat_d = mem_rdata;
        oe_d     = (cl_q == CL_2) ? rd_v_q : p1_v_q;
        dout_d   = (cl_q == CL_2) ? mem_rdata : p1_dat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                bank_st_q[b] <= BANK_IDLE;
                row_q[b]     <= '0;
                act_cnt_q[b] <= '0;
            end
            init_q     <= 1'b0;
            err_q      <= '0;
            cl_q       <= CL_3;
            bl_q       <= 2'd0;
            bst_act_q  <= 1'b0;
            bst_wr_q   <= 1'b0;
            bst_ap_q   <= 1'b0;
            bst_bank_q <= '0;
            bst_row_q  <= '0;
            bst_col_q  <= '0;
            bst_idx_q  <= '0;
            rd_v_q     <= 1'b0;
            p1_v_q     <= 1'b0;
            p1_dat_q   <= '0;
            oe_q       <= 1'b0;
            dout_q     <= '0;
        end else begin
            bank_st_q  <= bank_st_d;
            row_q      <= row_d;
            act_cnt_q  <= act_cnt_d;
            init_q     <= init_d;
            err_q      <= err_d;
            cl_q       <= cl_d;
            bl_q       <= bl_d;
            bst_act_q  <= bst_act_d;
            bst_wr_q   <= bst_wr_d;
            bst_ap_q   <= bst_ap_d;
            bst_bank_q <= bst_bank_d;
            bst_row_q  <= bst_row_d;
            bst_col_q  <= bst_col_d;
            bst_idx_q  <= bst_idx_d;
            rd_v_q     <= rd_v_d;
            p1_v_q     <= p1_v_d;
            p1_dat_q   <= p1_dat_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
        end
    end

    sdram_resp_mem #(
        .AW(MW)
    ) u_mem (
        .clk_i  (clk),
        .we_i   (mem_we),
        .be_i   ({~bus.data_mask_high, ~bus.data_mask_low}),
        .waddr_i(mem_waddr),
        .wdata_i(data),
        .raddr_i(mem_raddr),
        .rdata_o(mem_rdata)
    );

    assign data      = oe_q ? dout_q : {DQ_W{1'bz}};
    assign init_done = init_q;
    assign err       = err_q;
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, write/read, masks, wrap, truncation, errors, reset.
module tb_sdram_responder;

    localparam logic [3:0]  C_NOP = 4'b0111;
    localparam logic [3:0]  C_ACT = 4'b0011;
    localparam logic [3:0]  C_RD  = 4'b0101;
    localparam logic [3:0]  C_WR  = 4'b0100;
    localparam logic [3:0]  C_PRE = 4'b0010;
    localparam logic [3:0]  C_REF = 4'b0001;
    localparam logic [3:0]  C_MRS = 4'b0000;
    localparam logic [15:0] HIZ   = 16'hFFFF;

    logic        clk;
    logic        rst;
    logic        init_done;
    logic [3:0]  err;
    logic [15:0] tb_dq;
    logic        tb_dq_en;
    wire  [15:0] data;
    int          n_chk;
    int          n_err;

    sdram_responder_if #(.AW(12)) bus_if ();

    // Undriven DQ floats high so a released bus reads as all ones.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (data[g]);
    end
    assign data = tb_dq_en ? tb_dq : 16'hzzzz;

    sdram_responder #(
        .ROW_WIDTH(12),
        .COL_WIDTH(9),
        .ROW_KEEP (2),
        .TRCD     (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .data     (data),
        .init_done(init_done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs for the next rising edge; returns 1ns later, when DQ shows what that edge samples.
    task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [11:0] a,
                         input logic [15:0] d, input logic den, input logic [1:0] dm);
        @(negedge clk);
        {bus_if.cs_n, bus_if.ras_n, bus_if.cas_n, bus_if.we_n} = c;
        bus_if.bank_addr = ba;
        bus_if.addr      = a;
        tb_dq            = d;
        tb_dq_en         = den;
        {bus_if.data_mask_high, bus_if.data_mask_low} = dm;
        #1;
    endtask

    task automatic nop();
        drive(C_NOP, 2'd0, 12'h000, 16'h0000, 1'b0, 2'b00);
    endtask

    task automatic init_seq(input string tag);
        drive(C_PRE, 2'd0, 12'h400, 16'h0, 1'b0, 2'b00);
        drive(C_REF, 2'd0, 12'h000, 16'h0, 1'b0, 2'b00);
        drive(C_REF, 2'd0, 12'h000, 16'h0, 1'b0, 2'b00);
        drive(C_MRS, 2'd0, 12'h032, 16'h0, 1'b0, 2'b00);
        check({tag, "_pre_mrs"}, 16'(init_done), 16'h0);
        nop();
        check({tag, "_init_done"}, 16'(init_done), 16'h1);
        check({tag, "_err"}, 16'(err), 16'h0);
    endtask

    task automatic write4(input logic [1:0] ba, input logic [11:0] a,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3,
                          input logic [1:0] dm0, input logic [1:0] dmr);
        drive(C_WR,  ba,   a,       d0, 1'b1, dm0);
        drive(C_NOP, 2'd0, 12'h000, d1, 1'b1, dmr);
        drive(C_NOP, 2'd0, 12'h000, d2, 1'b1, dmr);
        drive(C_NOP, 2'd0, 12'h000, d3, 1'b1, dmr);
    endtask

    // READ at edge N: words seen at N+3..N+6 (CL=3), bus released at N+2 and N+7.
    task automatic read_burst(input string tag, input logic [1:0] ba, input logic [11:0] a,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp [4];
        exp = '{e0, e1, e2, e3};
        drive(C_RD, ba, a, 16'h0, 1'b0, 2'b00);
        nop();
        nop();
        check({tag, "_lead_z"}, data, HIZ);
        for (int i = 0; i < 4; i++) begin
            nop();
            check($sformatf("%s_w%0d", tag, i), data, exp[i]);
        end
        nop();
        check({tag, "_tail_z"}, data, HIZ);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        tb_dq = 16'h0;
        tb_dq_en = 1'b0;
        bus_if.clock_enable = 1'b1;
        {bus_if.cs_n, bus_if.ras_n, bus_if.cas_n, bus_if.we_n} = C_NOP;
        bus_if.bank_addr = 2'd0;
        bus_if.addr = 12'h000;
        bus_if.data_mask_low = 1'b0;
        bus_if.data_mask_high = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_init_done", 16'(init_done), 16'h0);
        check("rst_err", 16'(err), 16'h0);
        check("rst_data_z", data, HIZ);
        rst = 1'b0;

        init_seq("init");

        // Write with auto-precharge, then reopen the row and read it back.
        drive(C_ACT, 2'd1, 12'h005, 16'h0, 1'b0, 2'b00);
        nop();
        nop();
        write4(2'd1, 12'h410, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'b00, 2'b00);
        nop();
        drive(C_ACT, 2'd1, 12'h005, 16'h0, 1'b0, 2'b00);
        nop();
        check("ap_reopen_err", 16'(err), 16'h0);
        nop();
        read_burst("wr_rd", 2'd1, 12'h010, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        write4(2'd1, 12'h020, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 2'b00, 2'b00);
        write4(2'd1, 12'h020, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 2'b10, 2'b11);
        nop();
        read_burst("mask", 2'd1, 12'h020, 16'h12CD, 16'h5678, 16'h9ABC, 16'hDEF0);

        read_burst("wrap", 2'd1, 12'h013, 16'h4444, 16'h1111, 16'h2222, 16'h3333);

        // Second READ one edge later cuts the first burst after its in-flight word.
        drive(C_RD, 2'd1, 12'h010, 16'h0, 1'b0, 2'b00);
        drive(C_RD, 2'd1, 12'h020, 16'h0, 1'b0, 2'b00);
        nop();
        check("trunc_lead_z", data, HIZ);
        nop();
        check("trunc_first", data, 16'h1111);
        nop();
        check("trunc_w0", data, 16'h12CD);
        nop();
        check("trunc_w1", data, 16'h5678);
        nop();
        nop();
        nop();
        check("trunc_tail_z", data, HIZ);
        check("trunc_err", 16'(err), 16'h0);

        drive(C_RD, 2'd2, 12'h000, 16'h0, 1'b0, 2'b00);
        nop();
        check("idle_rd_err", 16'(err), 16'h1);
        nop();
        nop();
        check("idle_rd_z", data, HIZ);
        nop();
        check("idle_rd_z2", data, HIZ);
        drive(C_ACT, 2'd2, 12'h000, 16'h0, 1'b0, 2'b00);
        drive(C_RD,  2'd2, 12'h000, 16'h0, 1'b0, 2'b00);
        nop();
        check("trcd_err", 16'(err), 16'h9);
        repeat (7) nop();

        drive(C_RD, 2'd1, 12'h010, 16'h0, 1'b0, 2'b00);
        nop();
        nop();
        nop();
        check("rst_burst_w0", data, 16'h1111);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_data_z", data, HIZ);
        check("rst_mid_init", 16'(init_done), 16'h0);
        check("rst_mid_err", 16'(err), 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        init_seq("reinit");
        drive(C_ACT, 2'd1, 12'h005, 16'h0, 1'b0, 2'b00);
        nop();
        nop();
        read_burst("post_rst", 2'd1, 12'h010, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        check("post_rst_err", 16'(err), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
